hazard_control_unit: RTL and testbench

//   Closes the loop from the EX end of the ID/EX pipeline register back to the PC, IF/ID and ID/EX.

---
 rtl/hazard_control_unit.sv | 113 +++++++++++
 tb/tb_hazard_control_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Load-use stall and branch/jump flush control for the IF/ID and ID/EX pipeline registers,
// with saturating stall and flush performance counters.
module hazard_control_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             perf_clear,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned CW = $clog2(LOAD_STALL_CYCLES) + 1;

  typedef enum logic {RUN, STALL} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;
  logic             redir;

  assign hz = idex_MemRead && (idex_rt != 5'd0) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign redir = ex_branch_taken || ex_jump;

  // State, remaining-stall counter and performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Mealy decode; redirect beats a pending or new stall
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stalled     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (!reset) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (redir) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
    end else if (state_q == STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stalled     = 1'b1;
      cnt_d       = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = RUN;
      end
    end else if (hz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = STALL;
        cnt_d   = CW'(LOAD_STALL_CYCLES - 1);
      end
    end
  end

  // Saturating counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_write && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (redir && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three instances (L=1, L=3, L=1 with 2-bit counters)
// checked against a cycle-level behavioural model of stall budget and counters.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       ms, urt, bt, jp, pc;
  logic [4:0] irt, rs, rt;

  logic        pw0, iw0, fl0, bb0, st0;
  logic        pw1, iw1, fl1, bb1, st1;
  logic        pw2, iw2, fl2, bb2, st2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Model state per instance: stall cycles still owed, and counter values
  int m_len [3] = '{1, 3, 1};
  int m_max [3] = '{65535, 65535, 3};
  int m_rem [3];
  int m_sc  [3];
  int m_fc  [3];

  always #5 clk = ~clk;

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .idex_MemRead(ms), .idex_rt(irt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_uses_rt(urt), .ex_branch_taken(bt), .ex_jump(jp), .perf_clear(pc),
    .pc_write(pw0), .ifid_write(iw0), .ifid_flush(fl0), .idex_bubble(bb0), .stalled(st0),
    .stall_count(sc0), .flush_count(fc0));

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .idex_MemRead(ms), .idex_rt(irt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_uses_rt(urt), .ex_branch_taken(bt), .ex_jump(jp), .perf_clear(pc),
    .pc_write(pw1), .ifid_write(iw1), .ifid_flush(fl1), .idex_bubble(bb1), .stalled(st1),
    .stall_count(sc1), .flush_count(fc1));

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .idex_MemRead(ms), .idex_rt(irt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_uses_rt(urt), .ex_branch_taken(bt), .ex_jump(jp), .perf_clear(pc),
    .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2), .idex_bubble(bb2), .stalled(st2),
    .stall_count(sc2), .flush_count(fc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic u, input logic br,
                       input logic j, input logic clr);
    ms = m; irt = a; rs = b; rt = c; urt = u; bt = br; jp = j; pc = clr;
  endtask

  function automatic logic model_hz();
    return ms && (irt != 0) && ((irt == rs) || (urt && (irt == rt)));
  endfunction

  // Expected outputs of instance i for the current inputs and model state
  task automatic expect_out(input int i, output logic e_pw, output logic e_fl,
                            output logic e_bb, output logic e_st);
    e_pw = 1'b1; e_fl = 1'b0; e_bb = 1'b0; e_st = 1'b0;
    if (reset) begin
      if (bt || jp) begin
        e_fl = 1'b1; e_bb = 1'b1;
      end else if (m_rem[i] > 0) begin
        e_pw = 1'b0; e_bb = 1'b1; e_st = 1'b1;
      end else if (model_hz()) begin
        e_pw = 1'b0; e_bb = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic e_pw, e_fl, e_bb, e_st;
    logic o_pw, o_iw, o_fl, o_bb, o_st;
    logic [31:0] o_sc, o_fc;
    for (int i = 0; i < 3; i++) begin
      expect_out(i, e_pw, e_fl, e_bb, e_st);
      case (i)
        0: begin o_pw = pw0; o_iw = iw0; o_fl = fl0; o_bb = bb0; o_st = st0;
                 o_sc = 32'(sc0); o_fc = 32'(fc0); end
        1: begin o_pw = pw1; o_iw = iw1; o_fl = fl1; o_bb = bb1; o_st = st1;
                 o_sc = 32'(sc1); o_fc = 32'(fc1); end
        default: begin o_pw = pw2; o_iw = iw2; o_fl = fl2; o_bb = bb2; o_st = st2;
                 o_sc = 32'(sc2); o_fc = 32'(fc2); end
      endcase
      chk($sformatf("%s/u%0d/pc_write", tag, i), 32'(o_pw), 32'(e_pw));
      chk($sformatf("%s/u%0d/ifid_write", tag, i), 32'(o_iw), 32'(e_pw));
      chk($sformatf("%s/u%0d/ifid_flush", tag, i), 32'(o_fl), 32'(e_fl));
      chk($sformatf("%s/u%0d/idex_bubble", tag, i), 32'(o_bb), 32'(e_bb));
      chk($sformatf("%s/u%0d/stalled", tag, i), 32'(o_st), 32'(e_st));
      chk($sformatf("%s/u%0d/stall_count", tag, i), o_sc, 32'(m_sc[i]));
      chk($sformatf("%s/u%0d/flush_count", tag, i), o_fc, 32'(m_fc[i]));
    end
  endtask

  // Compare, then advance model and DUT across one rising edge
  task automatic cycle(input string tag);
    logic e_pw, e_fl, e_bb, e_st;
    logic hz_now;
    #1;
    check_all(tag);
    hz_now = model_hz();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      expect_out(i, e_pw, e_fl, e_bb, e_st);
      if (!reset) begin
        m_rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        if (pc) m_sc[i] = 0;
        else if (!e_pw) m_sc[i] = (m_sc[i] + 1 > m_max[i]) ? m_max[i] : m_sc[i] + 1;
        if (pc) m_fc[i] = 0;
        else if (bt || jp) m_fc[i] = (m_fc[i] + 1 > m_max[i]) ? m_max[i] : m_fc[i] + 1;
        if (bt || jp) m_rem[i] = 0;
        else if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
        else if (hz_now) m_rem[i] = m_len[i] - 1;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  initial begin
    model_reset();
    // Reset held with a live hazard present
    reset = 1'b0;
    drive(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0);
    cycle("reset_hz");
    cycle("reset_hz2");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle");

    // Single-cycle load-use hazard on rs
    drive(1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0);
    cycle("hz_rs");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle("after_hz_rs");

    // $0 destination and unused rt are never hazards
    drive(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    cycle("r0_mask");
    drive(1, 5'd9, 5'd1, 5'd9, 0, 0, 0, 0);
    cycle("rt_unused");
    drive(1, 5'd9, 5'd1, 5'd9, 1, 0, 0, 0);
    cycle("hz_rt");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle("after_hz_rt");

    // Redirect coinciding with a hazard, and both redirect sources together
    drive(1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0);
    cycle("br_plus_hz");
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    cycle("br_and_jump");
    // Redirect in the middle of the L=3 stall abandons it
    drive(1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0);
    cycle("hz_again");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("stall_mid");
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cycle("jump_in_stall");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("post_jump");

    // Saturate the 2-bit counters, then clear
    for (int k = 0; k < 5; k++) begin
      drive(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0);
      cycle("sat_hz");
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int w = 0; w < 3; w++) cycle("sat_gap");
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) cycle("sat_flush");
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cycle("clear");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("cleared");

    // Asynchronous reset in the middle of the L=3 stall
    drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    cycle("hz_pre_reset");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    model_reset();
    cycle("reset_mid_stall");
    @(negedge clk);
    reset = 1'b1;
    cycle("after_reset");

    // Random traffic over a small register set to provoke frequent hazards
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 40) == 0));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
